// File: rtl/alu_iter_seq.sv
// alu_iter_seq: multi-cycle command sequencer wrapped around an external
// combinational ALU. It performs unsigned divide by repeated subtraction and
// a 4-bit pattern-occurrence count over an 8-bit word, owning the ALU inputs
// while busy and returning results over a second valid/ready port.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. cmd_ready is high only in IDLE. rsp_valid is high only in
// DONE, and the response fields stay stable until rsp_ready is seen high.
module alu_iter_seq #(
    parameter logic [2:0] OP_SUB  = 3'b001,
    parameter logic [2:0] OP_SRL  = 3'b011,
    parameter logic [2:0] OP_IDLE = 3'b000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [3:0] cmd_pat,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_q,
    output logic [7:0] rsp_r,
    output logic       rsp_err,
    output logic       busy,
    output logic [2:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_ci,
    input  logic [7:0] alu_out,
    input  logic       alu_co,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIV_IT = 2'd1,
        S_PAT_IT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t state, state_nxt;

    // work holds the running remainder (DIV) or the shifting window (PAT)
    logic [7:0] work;
    logic [7:0] divisor;
    logic [3:0] pattern;
    logic [7:0] quot;
    logic [2:0] cnt;
    logic [2:0] match;
    logic       hit;
    logic [2:0] match_nxt;

    // The current window compares against the pattern before being shifted
    assign hit       = (work[3:0] == pattern);
    assign match_nxt = match + {2'b00, hit};
    assign state_dbg = state;

    // State register: reset aborts any operation back to IDLE
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op) begin
                        state_nxt = S_PAT_IT;
                    end else if (cmd_b == 8'd0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_DIV_IT;
                    end
                end
            end
            S_DIV_IT: begin
                // A borrow means the remainder is already below the divisor
                if (alu_co) begin
                    state_nxt = S_DONE;
                end
            end
            S_PAT_IT: begin
                if (cnt == 3'd4) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs: handshake flags and ALU drive decoded from the current state
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        alu_op    = OP_IDLE;
        alu_a     = 8'd0;
        alu_b     = 8'd0;
        alu_ci    = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_DIV_IT: begin
                alu_op = OP_SUB;
                alu_a  = work;
                alu_b  = divisor;
            end
            S_PAT_IT: begin
                alu_op = OP_SRL;
                alu_a  = work;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Datapath: operand capture, iteration updates and response latching
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            work    <= 8'd0;
            divisor <= 8'd0;
            pattern <= 4'd0;
            quot    <= 8'd0;
            cnt     <= 3'd0;
            match   <= 3'd0;
            rsp_q   <= 8'd0;
            rsp_r   <= 8'd0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        work    <= cmd_a;
                        divisor <= cmd_b;
                        pattern <= cmd_pat;
                        quot    <= 8'd0;
                        cnt     <= 3'd0;
                        match   <= 3'd0;
                        // Divide by zero skips iteration and reports directly
                        if (!cmd_op && (cmd_b == 8'd0)) begin
                            rsp_q   <= 8'hFF;
                            rsp_r   <= cmd_a;
                            rsp_err <= 1'b1;
                        end
                    end
                end
                S_DIV_IT: begin
                    if (!alu_co) begin
                        work <= alu_out;
                        quot <= quot + 8'd1;
                    end else begin
                        rsp_q   <= quot;
                        rsp_r   <= work;
                        rsp_err <= 1'b0;
                    end
                end
                S_PAT_IT: begin
                    match <= match_nxt;
                    work  <= alu_out;
                    cnt   <= cnt + 3'd1;
                    // The fifth window's compare is folded into the result
                    if (cnt == 3'd4) begin
                        rsp_q   <= 8'd0;
                        rsp_r   <= {5'd0, match_nxt};
                        rsp_err <= 1'b0;
                    end
                end
                default: begin
                    work <= work;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter_seq.sv
// Testbench for alu_iter_seq: provides a behavioural ALU, drives directed and
// random commands, and checks responses, latency and ALU drive against a
// reference model through an expected-response queue.
module tb_alu_iter_seq;

    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b011;
    localparam logic [2:0] OP_IDLE = 3'b000;

    logic       clk;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [3:0] cmd_pat;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_q;
    logic [7:0] rsp_r;
    logic       rsp_err;
    logic       busy;
    logic [2:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_ci;
    logic [7:0] alu_out;
    logic       alu_co;
    logic [1:0] state_dbg;

    // expected entry: [26] op, [25:17] iteration cycles, [16] err, [15:8] q, [7:0] r
    logic [26:0] exp_q[$];

    int total = 0;
    int bad   = 0;
    int ready_mode = 1;   // 0 hold low, 1 hold high, 2 random
    bit in_rst = 0;

    alu_iter_seq #(.OP_SUB(OP_SUB), .OP_SRL(OP_SRL), .OP_IDLE(OP_IDLE)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_pat(cmd_pat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err), .busy(busy),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
        .alu_out(alu_out), .alu_co(alu_co), .state_dbg(state_dbg)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural ALU
    always_comb begin
        logic [8:0] diff;
        diff    = {1'b0, alu_a} - {1'b0, alu_b} + {8'd0, alu_ci};
        alu_out = 8'd0;
        alu_co  = 1'b0;
        case (alu_op)
            OP_SUB: begin alu_out = diff[7:0]; alu_co = diff[8]; end
            OP_SRL: begin alu_out = alu_a >> 1; alu_co = alu_a[0]; end
            default: begin alu_out = 8'd0; alu_co = 1'b0; end
        endcase
    end

    // response consumer; changes well away from both clock edges
    always @(posedge clk) begin
        #2;
        if (ready_mode == 2) rsp_ready = 1'($urandom_range(0, 1));
        else rsp_ready = (ready_mode == 1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // reference model straight from the arithmetic definition
    function automatic logic [26:0] ref_model(input logic op, input logic [7:0] a,
                                              input logic [7:0] b, input logic [3:0] pat);
        int av, m, q, r;
        av = int'(a);
        if (op) begin
            m = 0;
            for (int i = 0; i < 5; i++) if (((av >> i) & 15) == int'(pat)) m++;
            return {1'b1, 9'd5, 1'b0, 8'd0, 8'(m)};
        end
        if (b == 8'd0) return {1'b0, 9'd0, 1'b1, 8'hFF, a};
        q = av / int'(b);
        r = av % int'(b);
        return {1'b0, 9'(q + 1), 1'b0, 8'(q), 8'(r)};
    endfunction

    // driver: offer a command, push its expectation once it will be taken
    task automatic send_cmd(input logic op, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] pat);
        int guard;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_pat   = pat;
        guard     = 0;
        while (!cmd_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            check("cmd_accept_timeout", 32'd0, 32'd1);
        end else begin
            exp_q.push_back(ref_model(op, a, b, pat));
            @(posedge clk);
        end
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", 32'(exp_q.size() != 0 || busy), 32'd0);
    endtask

    // monitor / scoreboard
    int          iter_cnt = 0;
    bit          prev_valid = 0;
    logic [16:0] prev_rsp;
    bit          after_pop = 0;

    always @(negedge clk) begin
        logic [26:0] e;
        if (!reset_n || in_rst) begin
            iter_cnt   = 0;
            prev_valid = 0;
            after_pop  = 0;
            if (in_rst) check("no_rsp_in_reset", 32'(rsp_valid), 32'd0);
        end else begin
            check("cmd_ready_vs_busy", 32'(cmd_ready), 32'(!busy));
            check("alu_ci_zero", 32'(alu_ci), 32'd0);
            if (after_pop) begin
                check("idle_after_rsp", 32'(busy), 32'd0);
                after_pop = 0;
            end
            if (busy && !rsp_valid) begin
                iter_cnt++;
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    check("alu_op_iter", 32'(alu_op), 32'(e[26] ? OP_SRL : OP_SUB));
                end
            end else begin
                check("alu_idle_drive", {21'd0, alu_op, alu_a, alu_b}, 32'd0);
            end
            if (rsp_valid) begin
                if (prev_valid)
                    check("rsp_stable", {15'd0, rsp_err, rsp_q, rsp_r}, {15'd0, prev_rsp});
                prev_valid = 1;
                prev_rsp   = {rsp_err, rsp_q, rsp_r};
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_err", 32'(rsp_err), 32'(e[16]));
                        check("rsp_q", 32'(rsp_q), 32'(e[15:8]));
                        check("rsp_r", 32'(rsp_r), 32'(e[7:0]));
                        check("iter_cycles", iter_cnt, 32'(e[25:17]));
                    end
                    iter_cnt   = 0;
                    prev_valid = 0;
                    after_pop  = 1;
                end
            end
        end
    end

    initial begin
        int guard;
        logic [7:0] a, b;
        logic [3:0] p;
        logic op;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_a     = 8'd0;
        cmd_b     = 8'd0;
        cmd_pat   = 4'd0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp", {15'd0, rsp_err, rsp_q, rsp_r}, 32'd0);
        reset_n = 1'b1;

        // reset in the middle of a long divide
        send_cmd(1'b0, 8'd200, 8'd3, 4'd0);
        repeat (10) @(negedge clk);
        check("busy_before_reset", 32'(busy), 32'd1);
        in_rst  = 1;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_rst_rsp", {15'd0, rsp_err, rsp_q, rsp_r}, 32'd0);
        check("post_rst_alu", {21'd0, alu_op, alu_a, alu_b}, 32'd0);
        repeat (3) @(negedge clk);
        in_rst = 0;

        // directed cases
        send_cmd(1'b0, 8'd100, 8'd7, 4'd0);
        send_cmd(1'b0, 8'd255, 8'd1, 4'd0);
        send_cmd(1'b0, 8'd5, 8'd9, 4'd0);
        send_cmd(1'b0, 8'd42, 8'd0, 4'd0);
        send_cmd(1'b1, 8'b1011_0110, 8'd0, 4'b1011);
        send_cmd(1'b1, 8'h00, 8'd0, 4'd0);
        send_cmd(1'b1, 8'hFF, 8'd0, 4'd0);
        wait_idle();

        // backpressure with a command offered while the response waits
        ready_mode = 0;
        send_cmd(1'b0, 8'd100, 8'd7, 4'd0);
        guard = 0;
        while (!rsp_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_a     = 8'd5;
        cmd_b     = 8'd9;
        repeat (3) begin
            @(negedge clk);
            check("bp_valid_held", 32'(rsp_valid), 32'd1);
            check("bp_cmd_blocked", 32'(cmd_ready), 32'd0);
        end
        ready_mode = 1;
        send_cmd(1'b0, 8'd5, 8'd9, 4'd0);
        wait_idle();

        // random commands with random consumer stalls
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            op = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 255));
            b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            p  = ($urandom_range(0, 1) == 1) ? a[3:0] : 4'($urandom_range(0, 15));
            send_cmd(op, a, b, p);
        end
        ready_mode = 1;
        wait_idle();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
